// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared types and default widths for the PUF access path
package puf_pkg;

   // Default widths shared with the TERO evaluation core
   localparam int PUF_CHALLENGE_BITS = 4;
   localparam int PUF_RESP_BITS      = 2;

   // Arbiter transaction phases
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LAUNCH  = 3'd1,
      WAIT    = 3'd2,
      RESPOND = 3'd3,
      GUARD   = 3'd4
   } puf_arb_state_t;

endpackage

// File: rtl/puf_rr_pick.sv
// rtl/puf_rr_pick.sv - combinational round-robin picker, searches upward from last_grant+1
module puf_rr_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
   output logic [$clog2(NUM_REQ)-1:0] winner_o,
   output logic                       any_req_o
);

   localparam int IW = $clog2(NUM_REQ);

   // Walk offsets from farthest to nearest so the nearest set bit after last_grant wins
   always_comb begin
      winner_o  = '0;
      any_req_o = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         int idx;
         idx = int'(last_grant_i) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (req_i[idx]) begin
            winner_o  = IW'(idx);
            any_req_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/puf_access_arbiter.sv
// rtl/puf_access_arbiter.sv - round-robin access arbiter for a shared TERO PUF core
module puf_access_arbiter
   import puf_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int CHALLENGE_BITS = PUF_CHALLENGE_BITS,
   parameter int RESP_BITS      = PUF_RESP_BITS,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GUARD_CYCLES   = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ*CHALLENGE_BITS-1:0] req_challenge,
   output logic [NUM_REQ-1:0]                grant,
   output logic [NUM_REQ-1:0]                ack,
   output logic [RESP_BITS-1:0]              resp_data,
   output logic                              resp_err,
   output logic                              busy,
   output logic                              core_start,
   output logic [CHALLENGE_BITS-1:0]         core_challenge,
   output logic                              core_abort,
   input  logic                              core_done,
   input  logic [RESP_BITS-1:0]              core_response
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 2);

   puf_arb_state_t            state_q;
   logic [IW-1:0]             last_grant_q;
   logic [IW-1:0]             owner_q;
   logic [NUM_REQ-1:0]        grant_q;
   logic [NUM_REQ-1:0]        ack_q;
   logic [RESP_BITS-1:0]      resp_data_q;
   logic                      resp_err_q;
   logic                      core_start_q;
   logic                      core_abort_q;
   logic [CHALLENGE_BITS-1:0] chal_q;
   logic [TW-1:0]             tcnt_q;
   logic [GW-1:0]             gcnt_q;

   logic [IW-1:0]             winner;
   logic                      any_req;
   logic [CHALLENGE_BITS-1:0] chal_slice [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign chal_slice[g] = req_challenge[g*CHALLENGE_BITS +: CHALLENGE_BITS];
   end

   puf_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .winner_o     (winner),
      .any_req_o    (any_req)
   );

   // Transaction FSM: arbitration, launch, watchdog, response handshake and settle interval
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= IW'(NUM_REQ - 1);
         owner_q      <= '0;
         grant_q      <= '0;
         ack_q        <= '0;
         resp_data_q  <= '0;
         resp_err_q   <= 1'b0;
         core_start_q <= 1'b0;
         core_abort_q <= 1'b0;
         chal_q       <= '0;
         tcnt_q       <= '0;
         gcnt_q       <= '0;
      end else begin
         core_start_q <= 1'b0;
         core_abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q      <= winner;
                  last_grant_q <= winner;
                  grant_q      <= NUM_REQ'(1) << winner;
                  chal_q       <= chal_slice[winner];
                  core_start_q <= 1'b1;
                  state_q      <= LAUNCH;
               end
            end
            LAUNCH: begin
               tcnt_q  <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               tcnt_q <= tcnt_q + TW'(1);
               // A completion in the last allowed cycle still counts as success
               if (core_done) begin
                  resp_data_q <= core_response;
                  resp_err_q  <= 1'b0;
                  ack_q       <= grant_q;
                  state_q     <= RESPOND;
               end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  resp_data_q  <= '0;
                  resp_err_q   <= 1'b1;
                  core_abort_q <= 1'b1;
                  ack_q        <= grant_q;
                  state_q      <= RESPOND;
               end
            end
            RESPOND: begin
               if (!req[owner_q]) begin
                  ack_q   <= '0;
                  grant_q <= '0;
                  gcnt_q  <= '0;
                  state_q <= (GUARD_CYCLES == 0) ? IDLE : GUARD;
               end
            end
            GUARD: begin
               if (gcnt_q == GW'(GUARD_CYCLES - 1)) begin
                  state_q <= IDLE;
               end else begin
                  gcnt_q <= gcnt_q + GW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant          = grant_q;
   assign ack            = ack_q;
   assign resp_data      = resp_data_q;
   assign resp_err       = resp_err_q;
   assign busy           = (state_q != IDLE);
   assign core_start     = core_start_q;
   assign core_challenge = chal_q;
   assign core_abort     = core_abort_q;

endmodule

// File: tb/tb_puf_access_arbiter.sv
// tb/tb_puf_access_arbiter.sv - directed table-driven bench for puf_access_arbiter
module tb_puf_access_arbiter;

   localparam int N  = 2;
   localparam int CB = 4;
   localparam int RB = 2;
   localparam int TO = 64;
   localparam int GC = 8;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N*CB-1:0] req_challenge;
   logic [N-1:0]    grant;
   logic [N-1:0]    ack;
   logic [RB-1:0]   resp_data;
   logic            resp_err;
   logic            busy;
   logic            core_start;
   logic [CB-1:0]   core_challenge;
   logic            core_abort;
   logic            core_done;
   logic [RB-1:0]   core_response;

   int checks;
   int failures;

   puf_access_arbiter #(
      .NUM_REQ        (N),
      .CHALLENGE_BITS (CB),
      .RESP_BITS      (RB),
      .TIMEOUT_CYCLES (TO),
      .GUARD_CYCLES   (GC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .req            (req),
      .req_challenge  (req_challenge),
      .grant          (grant),
      .ack            (ack),
      .resp_data      (resp_data),
      .resp_err       (resp_err),
      .busy           (busy),
      .core_start     (core_start),
      .core_challenge (core_challenge),
      .core_abort     (core_abort),
      .core_done      (core_done),
      .core_response  (core_response)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rq;
      logic [7:0] chal;
      int         own;
      logic [3:0] echal;
      int         d;
      logic [1:0] rsp;
      int         lat;
      logic [1:0] edata;
      logic       eerr;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Structural invariants every cycle outside reset
   always @(negedge clk) begin
      if (!reset) begin
         chk("grant onehot", int'($countones(grant) <= 1), 1);
         chk("ack within grant", int'((ack & ~grant) == '0), 1);
      end
   end

   task automatic wait_start(input int own, input logic [3:0] echal, input string tag, output int n);
      logic bad;
      n   = 0;
      bad = 1'b0;
      while (!core_start && n < 300) begin
         if (grant != '0) bad = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({tag, " start seen"}, int'(core_start), 1);
      chk({tag, " no grant before start"}, int'(bad), 0);
      chk({tag, " grant"}, int'(grant), 1 << own);
      chk({tag, " challenge"}, int'(core_challenge), int'(echal));
      chk({tag, " busy"}, int'(busy), 1);
      req_challenge = ~req_challenge;
   endtask

   task automatic finish_txn(input int d, input logic [1:0] rsp, input int lat,
                             input logic [1:0] edata, input logic eerr, input int own,
                             input string tag);
      int k;
      int aborts;
      int n;
      k      = 0;
      aborts = 0;
      while (k < 300) begin
         @(posedge clk); #1;
         k++;
         core_done     = (k == d);
         core_response = (k == d) ? rsp : 2'(k);
         @(negedge clk);
         if (ack != '0) break;
         aborts += int'(core_abort);
      end
      core_done = 1'b0;
      chk({tag, " ack latency"}, k, lat);
      chk({tag, " ack"}, int'(ack), 1 << own);
      chk({tag, " resp_data"}, int'(resp_data), int'(edata));
      chk({tag, " resp_err"}, int'(resp_err), int'(eerr));
      chk({tag, " abort at ack"}, int'(core_abort), int'(eerr));
      chk({tag, " abort before ack"}, aborts, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " ack held"}, int'(ack), 1 << own);
      chk({tag, " abort single"}, int'(core_abort), 0);
      @(posedge clk); #1;
      req[own] = 1'b0;
      @(negedge clk);
      chk({tag, " ack in drop cycle"}, int'(ack), 1 << own);
      @(negedge clk);
      chk({tag, " ack cleared"}, int'(ack), 0);
      chk({tag, " grant cleared"}, int'(grant), 0);
      chk({tag, " busy in guard"}, int'(busy), 1);
      if (req == '0) begin
         n = 0;
         while (busy && n < 100) begin
            n++;
            @(negedge clk);
         end
         chk({tag, " guard length"}, n, GC);
      end
   endtask

   task automatic run_txn(input vec_t v, input string tag);
      int n;
      req           = v.rq;
      req_challenge = v.chal;
      wait_start(v.own, v.echal, tag, n);
      finish_txn(v.d, v.rsp, v.lat, v.edata, v.eerr, v.own, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit");
      $fatal(1);
   end

   initial begin
      int n;
      int k;
      checks        = 0;
      failures      = 0;
      reset         = 1'b1;
      req           = '0;
      req_challenge = '0;
      core_done     = 1'b0;
      core_response = '0;

      //           rq     chal   own echal d    rsp    lat edata  eerr
      vecs[0] = '{2'b11, 8'h5C, 0, 4'hC, 5,  2'b01, 6,  2'b01, 1'b0};
      vecs[1] = '{2'b10, 8'h5C, 1, 4'h5, 3,  2'b11, 4,  2'b11, 1'b0};
      vecs[2] = '{2'b11, 8'h96, 0, 4'h6, 1,  2'b10, 2,  2'b10, 1'b0};
      vecs[3] = '{2'b10, 8'h96, 1, 4'h9, -1, 2'b11, 65, 2'b00, 1'b1};
      vecs[4] = '{2'b01, 8'h0A, 0, 4'hA, 20, 2'b10, 21, 2'b10, 1'b0};
      vecs[5] = '{2'b10, 8'h70, 1, 4'h7, 64, 2'b01, 65, 2'b01, 1'b0};
      vecs[6] = '{2'b01, 8'h0F, 0, 4'hF, 63, 2'b11, 64, 2'b11, 1'b0};

      repeat (3) @(negedge clk);
      chk("rst grant", int'(grant), 0);
      chk("rst ack", int'(ack), 0);
      chk("rst resp_data", int'(resp_data), 0);
      chk("rst resp_err", int'(resp_err), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst core_start", int'(core_start), 0);
      chk("rst core_challenge", int'(core_challenge), 0);
      chk("rst core_abort", int'(core_abort), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Guard interval with a pending requester
      run_txn('{2'b11, 8'h3C, 1, 4'h3, 2, 2'b01, 3, 2'b01, 1'b0}, "guard first");
      req_challenge = 8'h3C;
      wait_start(0, 4'hC, "guard second", n);
      chk("guard start gap ok", int'(n + 1 >= GC + 2), 1);
      finish_txn(5, 2'b10, 6, 2'b10, 1'b0, 0, "guard second");

      // Reset in the middle of WAIT
      req           = 2'b01;
      req_challenge = 8'h0E;
      wait_start(0, 4'hE, "pre reset", n);
      repeat (4) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      chk("async rst grant", int'(grant), 0);
      chk("async rst ack", int'(ack), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst challenge", int'(core_challenge), 0);
      chk("async rst resp_data", int'(resp_data), 0);
      chk("async rst start", int'(core_start), 0);
      req = '0;
      repeat (2) begin
         @(negedge clk);
         chk("no ack in reset", int'(ack), 0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      run_txn('{2'b10, 8'hB0, 1, 4'hB, 4, 2'b11, 5, 2'b11, 1'b0}, "post reset");

      // core_done in IDLE is ignored
      @(posedge clk); #1;
      core_done     = 1'b1;
      core_response = 2'b01;
      repeat (2) @(negedge clk);
      chk("idle done busy", int'(busy), 0);
      chk("idle done ack", int'(ack), 0);
      chk("idle done resp held", int'(resp_data), 3);

      // core_done held through LAUNCH is ignored
      req           = 2'b01;
      req_challenge = 8'h0D;
      wait_start(0, 4'hD, "launch done", n);
      finish_txn(10, 2'b01, 11, 2'b01, 1'b0, 0, "launch done");

      // Request withdrawn during WAIT still gets a one-cycle ack
      req           = 2'b01;
      req_challenge = 8'h04;
      wait_start(0, 4'h4, "early drop", n);
      k = 0;
      while (k < 20) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) req = '0;
         core_done     = (k == 3);
         core_response = 2'b11;
         @(negedge clk);
         if (ack != '0) break;
      end
      core_done = 1'b0;
      chk("early drop latency", k, 4);
      chk("early drop ack", int'(ack), 1);
      chk("early drop data", int'(resp_data), 3);
      @(negedge clk);
      chk("early drop ack cleared", int'(ack), 0);
      chk("early drop grant cleared", int'(grant), 0);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("early drop guard length", n, GC);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
